shift_register_univ: RTL and testbench
======================================

Name: shift_register_univ

Overview:
Parametrised universal shift register, the next generation of the serial/parallel load shift register. It adds multi-mode operation (load, clear, logical/arithmetic shift, rotate) and multi-step bursts driven by a valid/ready command handshake. An internal counter/FSM executes N single-bit steps, one per clock, and pulses a done flag. It is used as a datapath serializer/deserializer and bit-manipulation unit behind a simple command port.

Parameters:
BW_DATA, 8, register width in bits (>= 2)
BW_STEP, 3, width of step-count field; a burst executes 1 .. 2^BW_STEP steps

Ports:
i_Clk  input  1  clock, all state updates on rising edge
i_Rstn  input  1  reset, asynchronous, active-low
i_Valid  input  1  command valid
o_Ready  output  1  command ready; a command is accepted on a rising edge with i_Valid && o_Ready
i_Mode  input  3  command mode, sampled at accept
i_Steps  input  BW_STEP  steps minus one, sampled at accept (0 -> 1 step)
i_D  input  BW_DATA  parallel load data, sampled at accept
i_Sin  input  1  serial input, sampled live at every step edge
o_Qout  output  BW_DATA  register contents
o_Sout  output  1  bit that left the register on the most recent shift/rotate step
o_Done  output  1  one-cycle pulse after a command's final update
o_Busy  output  1  burst in progress (= ~o_Ready)

Behaviour:
- Reset (async assert, sync release): o_Qout=0, o_Sout=0, o_Done=0, FSM=IDLE (o_Ready=1, o_Busy=0). Reset mid-burst aborts the burst; no o_Done is produced.
- Mode encoding:
  - 0 HOLD: no-op.
  - 1 LOAD: Q<=i_D.
  - 2 CLR: Q<=0.
  - 3 SHL: Q<={Q[W-2:0],Sin}; Sout<=Q[W-1].
  - 4 SHR: Q<={Sin,Q[W-1:1]}; Sout<=Q[0].
  - 5 ROL: Q<={Q[W-2:0],Q[W-1]}; Sout<=Q[W-1].
  - 6 ROR: Q<={Q[0],Q[W-1:1]}; Sout<=Q[0].
  - 7 ASR: Q<={Q[W-1],Q[W-1:1]}; Sout<=Q[0]; Sin ignored.
- HOLD/LOAD/CLR are single-step; i_Steps is ignored. o_Sout is unchanged by these modes.
- FSM has two states, IDLE and RUN.
  - IDLE: o_Ready=1. On accept, step 1 executes at the accept edge. If total steps N=i_Steps+1 > 1, go to RUN with a remaining-step counter of N-1 and latch the mode.
  - RUN: o_Ready=0. One step executes per edge and the counter decrements. At the edge performing the last step, return to IDLE.
- Latency: o_Qout shows the final value N edges after accept (accept edge included). o_Done is high for exactly the cycle after the final-step edge. o_Ready is high in that same cycle, so a back-to-back command may be accepted while o_Done=1. Sustained throughput is one command per N cycles.
- i_Valid while o_Ready=0 is ignored: not queued, no effect. i_D, i_Mode and i_Steps changing during RUN have no effect.
- i_Steps=all-ones gives 2^BW_STEP steps, with no counter wrap. Counter width is BW_STEP.
- When N >= BW_DATA, SHL/SHR fully replace contents with Sin history; rotates wrap modulo BW_DATA naturally.

Decomposition:
- Package shift_register_pkg holds:
  - Mode localparams MODE_HOLD..MODE_ASR (3-bit).
  - FSM state localparams ST_IDLE, ST_RUN.
- Sub-module shift_step: purely combinational one-step next-value function.
  - Inputs: mode, Q, Sin, D.
  - Outputs: next Q, next Sout, sout_update flag.
  - Instantiated once; the top holds registers, counter and FSM.

Test Plan:
1. Reset: i_Rstn=0 with random inputs -> o_Qout=0x00, o_Sout=0, o_Ready=1, o_Done=0. Release; outputs hold.
2. LOAD i_D=0xA5 -> next cycle o_Qout=0xA5, o_Done=1 for one cycle, o_Ready stays 1. Back-to-back CLR in the o_Done cycle -> o_Qout=0x00, second o_Done pulse.
3. From 0xA5, SHL i_Steps=3, i_Sin=1 -> o_Ready=0 for 3 cycles. After 4 edges o_Qout=0x5F and o_Sout=0, with o_Sout sequence 1,0,1,0. o_Done one cycle after the 4th edge.
4. From 0x81: ROR i_Steps=0 -> o_Qout=0xC0, o_Sout=1. Then ASR from 0x80 with i_Steps=2 -> o_Qout=0xF0, o_Sout=0.
5. SHR i_Steps=7 from 0xFF with i_Sin=0. Pulse i_Valid with LOAD 0x3C at cycle 3 -> load ignored. After 8 edges o_Qout=0x00, o_Sout=1, exactly one o_Done.
6. SHR burst i_Steps=7, assert i_Rstn=0 after 2 steps -> o_Qout=0x00, o_Ready=1 immediately (async), no o_Done. A new command after release executes normally.

Source files
------------

// File: rtl/shift_register_pkg.sv
// Shared definitions for the universal shift register:
// command mode codes, FSM state codes and a burst-mode helper.
package shift_register_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_CLR  = 3'd2;
    localparam logic [2:0] MODE_SHL  = 3'd3;
    localparam logic [2:0] MODE_SHR  = 3'd4;
    localparam logic [2:0] MODE_ROL  = 3'd5;
    localparam logic [2:0] MODE_ROR  = 3'd6;
    localparam logic [2:0] MODE_ASR  = 3'd7;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // Shift/rotate modes honour the step count; the rest are one-shot.
    function automatic logic is_burst_mode(input logic [2:0] mode);
        return mode >= MODE_SHL;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One-step next-value function of the universal shift register.
// Purely combinational; the top owns all state.
module shift_step
    import shift_register_pkg::*;
#(
    parameter int BW_DATA = 8
) (
    input  logic [2:0]         mode,
    input  logic [BW_DATA-1:0] q,
    input  logic               sin,
    input  logic [BW_DATA-1:0] d,
    output logic [BW_DATA-1:0] q_next,
    output logic               sout_next,
    output logic               sout_update
);

    // Decode the mode into the next register value and exiting bit.
    always_comb begin
        q_next      = q;
        sout_next   = 1'b0;
        sout_update = 1'b0;
        unique case (mode)
            MODE_HOLD: q_next = q;
            MODE_LOAD: q_next = d;
            MODE_CLR:  q_next = '0;
            MODE_SHL: begin
                q_next      = {q[BW_DATA-2:0], sin};
                sout_next   = q[BW_DATA-1];
                sout_update = 1'b1;
            end
            MODE_SHR: begin
                q_next      = {sin, q[BW_DATA-1:1]};
                sout_next   = q[0];
                sout_update = 1'b1;
            end
            MODE_ROL: begin
                q_next      = {q[BW_DATA-2:0], q[BW_DATA-1]};
                sout_next   = q[BW_DATA-1];
                sout_update = 1'b1;
            end
            MODE_ROR: begin
                q_next      = {q[0], q[BW_DATA-1:1]};
                sout_next   = q[0];
                sout_update = 1'b1;
            end
            MODE_ASR: begin
                q_next      = {q[BW_DATA-1], q[BW_DATA-1:1]};
                sout_next   = q[0];
                sout_update = 1'b1;
            end
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/shift_register_univ.sv
// Universal shift register with a valid/ready command port.
// Step 1 runs at the accept edge; a counter runs the remaining steps.
module shift_register_univ
    import shift_register_pkg::*;
#(
    parameter int BW_DATA = 8,
    parameter int BW_STEP = 3
) (
    input  logic               i_Clk,
    input  logic               i_Rstn,
    input  logic               i_Valid,
    output logic               o_Ready,
    input  logic [2:0]         i_Mode,
    input  logic [BW_STEP-1:0] i_Steps,
    input  logic [BW_DATA-1:0] i_D,
    input  logic               i_Sin,
    output logic [BW_DATA-1:0] o_Qout,
    output logic               o_Sout,
    output logic               o_Done,
    output logic               o_Busy
);

    localparam logic [BW_STEP-1:0] CNT_ONE = BW_STEP'(1);

    logic               state;
    logic               state_nxt;
    logic [BW_STEP-1:0] cnt;
    logic [2:0]         mode_q;
    logic               accept;
    logic               multi;
    logic               last_step;
    logic               step_en;
    logic [2:0]         step_mode;
    logic [BW_DATA-1:0] q_next;
    logic               sout_next;
    logic               sout_update;

    assign accept    = i_Valid && (state == ST_IDLE);
    assign multi     = is_burst_mode(i_Mode) && (i_Steps != '0);
    assign last_step = (state == ST_RUN) && (cnt == CNT_ONE);
    assign step_en   = accept || (state == ST_RUN);
    assign step_mode = (state == ST_RUN) ? mode_q : i_Mode;

    shift_step #(
        .BW_DATA (BW_DATA)
    ) u_step (
        .mode        (step_mode),
        .q           (o_Qout),
        .sin         (i_Sin),
        .d           (i_D),
        .q_next      (q_next),
        .sout_next   (sout_next),
        .sout_update (sout_update)
    );

    // FSM state register.
    always_ff @(posedge i_Clk or negedge i_Rstn) begin
        if (!i_Rstn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Enter RUN for multi-step bursts, leave on the last step.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept && multi) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == CNT_ONE)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs follow the state directly.
    always_comb begin
        o_Ready = (state == ST_IDLE);
        o_Busy  = (state != ST_IDLE);
    end

    // Remaining-step counter and latched burst mode.
    always_ff @(posedge i_Clk or negedge i_Rstn) begin
        if (!i_Rstn) begin
            cnt    <= '0;
            mode_q <= MODE_HOLD;
        end else if (accept && multi) begin
            cnt    <= i_Steps;
            mode_q <= i_Mode;
        end else if (state == ST_RUN) begin
            cnt    <= cnt - CNT_ONE;
        end
    end

    // Data register and serial-out bit, one step per enabled edge.
    always_ff @(posedge i_Clk or negedge i_Rstn) begin
        if (!i_Rstn) begin
            o_Qout <= '0;
            o_Sout <= 1'b0;
        end else if (step_en) begin
            o_Qout <= q_next;
            if (sout_update) o_Sout <= sout_next;
        end
    end

    // Done pulses the cycle after a command's final update.
    always_ff @(posedge i_Clk or negedge i_Rstn) begin
        if (!i_Rstn) o_Done <= 1'b0;
        else         o_Done <= (accept && !multi) || last_step;
    end

endmodule

// File: tb/tb_shift_register_univ.sv
// Scoreboard bench for shift_register_univ: directed scenarios
// plus random commands checked against an arithmetic reference.
module tb_shift_register_univ;

    localparam int W = 8;
    localparam int S = 3;

    typedef struct {
        logic [W-1:0] q;
        logic         sout;
    } exp_t;

    logic         i_Clk = 1'b0;
    logic         i_Rstn = 1'b0;
    logic         i_Valid = 1'b0;
    logic [2:0]   i_Mode = '0;
    logic [S-1:0] i_Steps = '0;
    logic [W-1:0] i_D = '0;
    logic         i_Sin = 1'b0;
    logic         o_Ready;
    logic [W-1:0] o_Qout;
    logic         o_Sout;
    logic         o_Done;
    logic         o_Busy;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int d0;
    logic [W-1:0] m_q = '0;
    logic         m_sout = 1'b0;
    exp_t         exp_q[$];

    shift_register_univ #(
        .BW_DATA (W),
        .BW_STEP (S)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Rstn  (i_Rstn),
        .i_Valid (i_Valid),
        .o_Ready (o_Ready),
        .i_Mode  (i_Mode),
        .i_Steps (i_Steps),
        .i_D     (i_D),
        .i_Sin   (i_Sin),
        .o_Qout  (o_Qout),
        .o_Sout  (o_Sout),
        .o_Done  (o_Done),
        .o_Busy  (o_Busy)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Reference: whole-burst result from plain arithmetic on wide values.
    task automatic model(input logic [2:0] mode, input int n,
                         input logic [W-1:0] d, input logic sin);
        longint unsigned ext;
        longint unsigned fill;
        longint unsigned tmp;
        longint          sq;
        int              r;
        fill = sin ? ((64'd1 << n) - 64'd1) : 64'd0;
        r = n % W;
        case (mode)
            3'd1: m_q = d;
            3'd2: m_q = '0;
            3'd3: begin
                ext = ({56'd0, m_q} << n) | fill;
                m_sout = ext[W];
                m_q = ext[W-1:0];
            end
            3'd4: begin
                ext = (fill << W) | {56'd0, m_q};
                m_sout = ext[n-1];
                tmp = ext >> n;
                m_q = tmp[W-1:0];
            end
            3'd5: begin
                ext = {56'd0, m_q};
                tmp = (ext << r) | (ext >> (W - r));
                m_q = tmp[W-1:0];
                m_sout = m_q[0];
            end
            3'd6: begin
                ext = {56'd0, m_q};
                tmp = (ext >> r) | (ext << (W - r));
                m_q = tmp[W-1:0];
                m_sout = m_q[W-1];
            end
            3'd7: begin
                sq = m_q[W-1] ? (longint'(m_q) - (longint'(1) << W))
                              : longint'(m_q);
                tmp = longint'(sq >>> n);
                m_q = tmp[W-1:0];
                tmp = longint'(sq >>> (n - 1));
                m_sout = tmp[0];
            end
            default: ;
        endcase
    endtask

    // Wait for ready, present one command, push its expected result.
    task automatic issue(input logic [2:0] mode, input logic [S-1:0] steps,
                         input logic [W-1:0] d, input logic sin);
        int k = 0;
        while (!o_Ready && k < 200) begin
            @(negedge i_Clk);
            k++;
        end
        if (!o_Ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got busy want ready");
            return;
        end
        i_Valid = 1'b1;
        i_Mode  = mode;
        i_Steps = steps;
        i_D     = d;
        i_Sin   = sin;
        model(mode, int'(steps) + 1, d, sin);
        exp_q.push_back('{m_q, m_sout});
        @(posedge i_Clk);
        #1;
        i_Valid = 1'b0;
        i_Mode  = 3'($urandom);
        i_Steps = S'($urandom);
        i_D     = W'($urandom);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge i_Clk);
            k++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0",
                     exp_q.size());
        end
    endtask

    // Monitor: every done pulse retires one expected result.
    always @(negedge i_Clk) begin
        if (i_Rstn && o_Done) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want none");
            end else begin
                e = exp_q.pop_front();
                check("done_q", 32'(o_Qout), 32'(e.q));
                check("done_sout", 32'(o_Sout), 32'(e.sout));
            end
        end
    end

    initial begin
        // Reset with random inputs.
        i_Valid = 1'b1;
        i_Mode  = 3'($urandom);
        i_Steps = S'($urandom);
        i_D     = W'($urandom);
        i_Sin   = 1'($urandom);
        #12;
        check("rst_q", 32'(o_Qout), 32'h00);
        check("rst_sout", 32'(o_Sout), 32'h0);
        check("rst_ready", 32'(o_Ready), 32'h1);
        check("rst_done", 32'(o_Done), 32'h0);
        @(negedge i_Clk);
        i_Valid = 1'b0;
        i_Rstn = 1'b1;
        repeat (2) @(negedge i_Clk);
        check("rel_q", 32'(o_Qout), 32'h00);
        check("rel_ready", 32'(o_Ready), 32'h1);
        check("rel_busy", 32'(o_Busy), 32'h0);

        // LOAD then back-to-back CLR in the done cycle.
        d0 = done_cnt;
        issue(3'd1, 3'd0, 8'hA5, 1'b0);
        check("load_ready", 32'(o_Ready), 32'h1);
        check("load_done", 32'(o_Done), 32'h1);
        check("load_q", 32'(o_Qout), 32'hA5);
        issue(3'd2, 3'd5, 8'h77, 1'b0);
        drain();
        check("b2b_dones", 32'(done_cnt - d0), 32'd2);

        // SHL x4 from 0xA5 with Sin=1.
        issue(3'd1, 3'd0, 8'hA5, 1'b0);
        issue(3'd3, 3'd3, 8'h00, 1'b1);
        check("shl_sout1", 32'(o_Sout), 32'h1);
        check("shl_busy1", 32'(o_Ready), 32'h0);
        @(posedge i_Clk);
        #1;
        check("shl_sout2", 32'(o_Sout), 32'h0);
        check("shl_busy2", 32'(o_Ready), 32'h0);
        @(posedge i_Clk);
        #1;
        check("shl_sout3", 32'(o_Sout), 32'h1);
        check("shl_busy3", 32'(o_Busy), 32'h1);
        @(posedge i_Clk);
        #1;
        check("shl_q", 32'(o_Qout), 32'h5F);
        check("shl_sout4", 32'(o_Sout), 32'h0);
        check("shl_done", 32'(o_Done), 32'h1);
        check("shl_ready", 32'(o_Ready), 32'h1);

        // ROR single step and ASR x3.
        issue(3'd1, 3'd0, 8'h81, 1'b0);
        issue(3'd6, 3'd0, 8'h00, 1'b0);
        drain();
        check("ror_q", 32'(o_Qout), 32'hC0);
        check("ror_sout", 32'(o_Sout), 32'h1);
        issue(3'd1, 3'd0, 8'h80, 1'b0);
        issue(3'd7, 3'd2, 8'h00, 1'b1);
        drain();
        check("asr_q", 32'(o_Qout), 32'hF0);
        check("asr_sout", 32'(o_Sout), 32'h0);

        // SHR x8 with an ignored LOAD pulse mid-burst.
        issue(3'd1, 3'd0, 8'hFF, 1'b0);
        drain();
        d0 = done_cnt;
        issue(3'd4, 3'd7, 8'h00, 1'b0);
        repeat (2) @(negedge i_Clk);
        i_Valid = 1'b1;
        i_Mode  = 3'd1;
        i_D     = 8'h3C;
        @(posedge i_Clk);
        #1;
        i_Valid = 1'b0;
        drain();
        check("shr_q", 32'(o_Qout), 32'h00);
        check("shr_sout", 32'(o_Sout), 32'h1);
        check("shr_dones", 32'(done_cnt - d0), 32'd1);

        // Reset mid-burst aborts without a done pulse.
        issue(3'd1, 3'd0, 8'hF0, 1'b0);
        drain();
        issue(3'd4, 3'd7, 8'h00, 1'b1);
        @(posedge i_Clk);
        #2;
        i_Rstn = 1'b0;
        exp_q.delete();
        m_q = '0;
        m_sout = 1'b0;
        d0 = done_cnt;
        #1;
        check("abort_q", 32'(o_Qout), 32'h00);
        check("abort_ready", 32'(o_Ready), 32'h1);
        check("abort_done", 32'(o_Done), 32'h0);
        repeat (2) @(negedge i_Clk);
        i_Rstn = 1'b1;
        repeat (10) @(negedge i_Clk);
        check("abort_nodone", 32'(done_cnt - d0), 32'd0);
        issue(3'd1, 3'd0, 8'h5A, 1'b0);
        drain();
        check("post_abort_q", 32'(o_Qout), 32'h5A);

        // Random command stream.
        for (int i = 0; i < 80; i++) begin
            issue(3'($urandom), S'($urandom), W'($urandom), 1'($urandom));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
